// File: rtl/npu_mac_sequencer.sv
// Lockstep MAC-window sequencer for the NPU PE array: clear, K*K taps, pipeline drain, done.
// Optional busy-cycle counter enabled by defining NPU_SEQ_PERF_EN.
module npu_mac_sequencer #(
  parameter int N        = 10,
  parameter int K_SIZE   = 3,
  parameter int PIPE_LAT = 2,
  parameter int W_SEL_W  = $clog2(K_SIZE*K_SIZE),
  parameter int I_SEL_W  = $clog2(2*K_SIZE*K_SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               bcast,
  input  logic               acc_mode,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               buf_wr_block,
  output logic               pe_en,
  output logic               pe_reg_reset,
  output logic               pe_mode_sel,
  output logic [W_SEL_W-1:0] w_sel,
  output logic [I_SEL_W-1:0] in_sel,
  output logic [31:0]        perf_cycles
);

  localparam int TAPS = K_SIZE * K_SIZE;
  localparam int DR_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [W_SEL_W-1:0] LAST_TAP   = W_SEL_W'(TAPS - 1);
  localparam logic [DR_W-1:0]    DRAIN_LOAD = (PIPE_LAT > 0) ? DR_W'(PIPE_LAT - 1) : {DR_W{1'b0}};
  localparam logic [I_SEL_W-1:0] DIRECT_OFS = I_SEL_W'(TAPS);

  if (N < 1) begin : g_n_invalid
    $error("npu_mac_sequencer: N must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [W_SEL_W-1:0]  tap_r, tap_s;
  logic [DR_W-1:0]     drain_r, drain_s;
  logic                bcast_r, bcast_s;
  logic                mode_r, mode_s;

  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                aborted_r, aborted_s;
  logic                pe_en_r, pe_en_s;
  logic                pe_reg_reset_r, pe_reg_reset_s;
  logic                pe_mode_sel_r, pe_mode_sel_s;
  logic [W_SEL_W-1:0]  w_sel_r, w_sel_s;
  logic [I_SEL_W-1:0]  in_sel_r, in_sel_s;

  // Next-state, counter and latch logic.
  always_comb begin
    state_s   = state_r;
    tap_s     = tap_r;
    drain_s   = drain_r;
    bcast_s   = bcast_r;
    mode_s    = mode_r;
    aborted_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // a simultaneous abort suppresses the start without reporting a cancellation
        if (start && !abort) begin
          state_s = ST_CLR;
          bcast_s = bcast;
          mode_s  = acc_mode;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLR: begin
        if (abort) begin
          state_s   = ST_IDLE;
          aborted_s = 1'b1;
          tap_s     = {W_SEL_W{1'b0}};
        end else begin
          state_s = ST_MAC;
          tap_s   = {W_SEL_W{1'b0}};
        end
      end
      ST_MAC: begin
        if (abort) begin
          state_s   = ST_IDLE;
          aborted_s = 1'b1;
          tap_s     = {W_SEL_W{1'b0}};
        end else if (tap_r == LAST_TAP) begin
          state_s = (PIPE_LAT > 0) ? ST_DRAIN : ST_DONE;
          drain_s = DRAIN_LOAD;
        end else begin
          tap_s = tap_r + W_SEL_W'(1);
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_s   = ST_IDLE;
          aborted_s = 1'b1;
          tap_s     = {W_SEL_W{1'b0}};
          drain_s   = {DR_W{1'b0}};
        end else if (drain_r == {DR_W{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          drain_s = drain_r - DR_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        tap_s   = {W_SEL_W{1'b0}};
      end
      default: begin
        state_s = ST_IDLE;
        tap_s   = {W_SEL_W{1'b0}};
        drain_s = {DR_W{1'b0}};
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    busy_s         = (state_s != ST_IDLE);
    done_s         = 1'b0;
    pe_en_s        = 1'b0;
    pe_reg_reset_s = 1'b0;
    w_sel_s        = {W_SEL_W{1'b0}};
    in_sel_s       = {I_SEL_W{1'b0}};
    pe_mode_sel_s  = busy_s ? mode_s : 1'b0;
    case (state_s)
      ST_CLR: begin
        pe_reg_reset_s = 1'b1;
      end
      ST_MAC, ST_DRAIN: begin
        pe_en_s  = 1'b1;
        w_sel_s  = tap_s;
        in_sel_s = bcast_s ? I_SEL_W'(tap_s) : (I_SEL_W'(tap_s) + DIRECT_OFS);
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // State, counters, latched run options and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      tap_r          <= {W_SEL_W{1'b0}};
      drain_r        <= {DR_W{1'b0}};
      bcast_r        <= 1'b0;
      mode_r         <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      aborted_r      <= 1'b0;
      pe_en_r        <= 1'b0;
      pe_reg_reset_r <= 1'b0;
      pe_mode_sel_r  <= 1'b0;
      w_sel_r        <= {W_SEL_W{1'b0}};
      in_sel_r       <= {I_SEL_W{1'b0}};
    end else begin
      state_r        <= state_s;
      tap_r          <= tap_s;
      drain_r        <= drain_s;
      bcast_r        <= bcast_s;
      mode_r         <= mode_s;
      busy_r         <= busy_s;
      done_r         <= done_s;
      aborted_r      <= aborted_s;
      pe_en_r        <= pe_en_s;
      pe_reg_reset_r <= pe_reg_reset_s;
      pe_mode_sel_r  <= pe_mode_sel_s;
      w_sel_r        <= w_sel_s;
      in_sel_r       <= in_sel_s;
    end
  end

  assign busy         = busy_r;
  assign buf_wr_block = busy_r;
  assign done         = done_r;
  assign aborted      = aborted_r;
  assign pe_en        = pe_en_r;
  assign pe_reg_reset = pe_reg_reset_r;
  assign pe_mode_sel  = pe_mode_sel_r;
  assign w_sel        = w_sel_r;
  assign in_sel       = in_sel_r;

`ifdef NPU_SEQ_PERF_EN
  logic [31:0] perf_r;

  // Saturating count of busy cycles, including cancelled runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_r <= 32'd0;
    end else if (busy_r && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_cycles = perf_r;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_npu_mac_sequencer.sv
// Randomized and directed bench for npu_mac_sequencer, checked against a run-timeline model.
module tb_npu_mac_sequencer;

  localparam int K_SIZE   = 3;
  localparam int PIPE_LAT = 2;
  localparam int TAPS     = K_SIZE * K_SIZE;
  localparam int DONE_R   = TAPS + PIPE_LAT + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, bcast = 1'b0, acc_mode = 1'b0, abort = 1'b0;
  logic        busy, done, aborted, buf_wr_block, pe_en, pe_reg_reset, pe_mode_sel;
  logic [3:0]  w_sel;
  logic [4:0]  in_sel;
  logic [31:0] perf_cycles;

  int errors = 0;
  int checks = 0;

  // run-timeline model: m_r is the cycle index since the accepted start (1 = clear cycle)
  bit     m_active = 1'b0;
  int     m_r = 0;
  bit     m_b = 1'b0, m_m = 1'b0, m_abt = 1'b0;
  longint m_perf = 0;

  npu_mac_sequencer #(.N(10), .K_SIZE(K_SIZE), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .bcast(bcast), .acc_mode(acc_mode),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .buf_wr_block(buf_wr_block), .pe_en(pe_en), .pe_reg_reset(pe_reg_reset),
    .pe_mode_sel(pe_mode_sel), .w_sel(w_sel), .in_sel(in_sel), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int  ws;
    int  is;
    bit  sel_on;
    sel_on = m_active && (m_r >= 2) && (m_r < DONE_R);
    ws = !sel_on ? 0 : (m_r <= TAPS + 1) ? (m_r - 2) : (TAPS - 1);
    is = !sel_on ? 0 : (m_b ? ws : ws + TAPS);
    check_val("busy",         {31'd0, busy},         {31'd0, m_active});
    check_val("buf_wr_block", {31'd0, buf_wr_block}, {31'd0, m_active});
    check_val("done",         {31'd0, done},         {31'd0, m_active && m_r == DONE_R});
    check_val("aborted",      {31'd0, aborted},      {31'd0, m_abt});
    check_val("pe_en",        {31'd0, pe_en},        {31'd0, sel_on});
    check_val("pe_reg_reset", {31'd0, pe_reg_reset}, {31'd0, m_active && m_r == 1});
    check_val("pe_mode_sel",  {31'd0, pe_mode_sel},  {31'd0, m_active && m_m});
    check_val("w_sel",        {28'd0, w_sel},        32'(ws));
    check_val("in_sel",       {27'd0, in_sel},       32'(is));
`ifdef NPU_SEQ_PERF_EN
    check_val("perf_cycles",  perf_cycles,           32'(m_perf));
`else
    check_val("perf_cycles",  perf_cycles,           32'd0);
`endif
  endtask

  task automatic model_step();
    m_abt = 1'b0;
    if (m_active && m_perf < 64'hFFFF_FFFF) m_perf++;
    if (!m_active) begin
      if (start && !abort) begin
        m_active = 1'b1; m_r = 1; m_b = bcast; m_m = acc_mode;
      end
    end else if (m_r == DONE_R) begin
      m_active = 1'b0;
    end else if (abort) begin
      m_active = 1'b0; m_abt = 1'b1;
    end else begin
      m_r++;
    end
  endtask

  task automatic cyc(input logic s, input logic a, input logic b, input logic m);
    @(negedge clk);
    check_all();
    start = s; abort = a; bcast = b; acc_mode = m;
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0; abort = 1'b0;
    m_active = 1'b0; m_abt = 1'b0; m_r = 0; m_perf = 0;
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    // baseline run, direct bank, accumulate mode
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (15) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    // broadcast run
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (15) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    // extra starts at cycles 5 and 13 are ignored
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 15; i++) cyc((i == 5 || i == 13), 1'b0, 1'b1, 1'b0);
    // abort in MAC at tap 4, then idle for 20 cycles
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 22; i++) cyc(1'b0, (i == 6), 1'b0, 1'b0);
    // abort during CLR and during DRAIN, and on DONE (ignored)
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) cyc(1'b0, (i == 1), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 14; i++) cyc(1'b0, (i == 12), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) cyc(1'b0, (i == 13), 1'b0, 1'b0);
    // start with abort in IDLE
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    // back-to-back runs from a fresh reset
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (13) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (14) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
`ifdef NPU_SEQ_PERF_EN
    check_val("perf_two_runs", perf_cycles, 32'd26);
`else
    check_val("perf_two_runs", perf_cycles, 32'd0);
`endif
    // reset asserted mid-run at cycle 8, no done or aborted afterwards
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (7) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    repeat (16) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(3) == 0), ($urandom_range(19) == 0),
          1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    repeat (16) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npu_mac_sequencer.md
Name: npu_mac_sequencer

Overview:
- Controller for the NPU PE array. Sequences one K×K convolution window across all N PEs in lockstep.
- Drives the shared weight-mux select, the input-mux select, and the pe_core controls (pe_en, reg_reset, mode_sel).
- Started by a pulse from the CPU-facing register wrapper. Reports busy/done back to it, and blocks buffer writes while a run is in flight.

Parameters:
- N, 10, number of PE cores (informational; all PEs share the same selects)
- K_SIZE, 3, kernel edge; taps per run = K_SIZE*K_SIZE
- PIPE_LAT, 2, pe_core multiply/accumulate pipeline depth in cycles; drain length after last tap (0 allowed)
- W_SEL_W, $clog2(K_SIZE*K_SIZE), weight select width
- I_SEL_W, $clog2(2*K_SIZE*K_SIZE), input select width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  run request pulse; sampled only in IDLE
- bcast  input  1  input source for the run: 1 = broadcast bank, 0 = per-PE direct bank; latched at accepted start
- acc_mode  input  1  PE accumulate mode; latched at accepted start, driven on pe_mode_sel
- abort  input  1  cancel current run
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on normal completion
- aborted  output  1  one-cycle pulse when a run is cancelled
- buf_wr_block  output  1  equals busy; wrapper must drop buffer writes while high
- pe_en  output  1  PE enable
- pe_reg_reset  output  1  synchronous accumulator clear to all PEs
- pe_mode_sel  output  1  latched acc_mode
- w_sel  output  W_SEL_W  weight tap index
- in_sel  output  I_SEL_W  input mux index
- perf_cycles  output  32  busy-cycle counter (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; latched bcast/acc_mode 0; tap counter 0; drain counter 0.
- All outputs are registered, Moore-style, and reflect the current state.
- States: IDLE, CLR, MAC, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0 → CLR; latch bcast and acc_mode.
  - start=1 and abort=1 in the same cycle: abort wins, start ignored, no aborted pulse.
- CLR (1 cycle): pe_reg_reset=1, pe_en=0 → MAC with tap=0.
- MAC (K_SIZE*K_SIZE cycles):
  - pe_en=1, w_sel=tap.
  - in_sel = bcast ? tap : tap + K_SIZE*K_SIZE. The input mux packs broadcast taps at indices 0..K²-1 and direct taps at K²..2K²-1.
  - tap increments each cycle.
  - At tap = K_SIZE*K_SIZE-1 → DRAIN if PIPE_LAT>0, else DONE.
- DRAIN (PIPE_LAT cycles): pe_en=1, selects held at the last tap, counter counts down → DONE.
- DONE (1 cycle): done=1, pe_en=0 → IDLE.
- start is ignored in every state except IDLE, including DONE.
- Latency (start sampled at cycle 0): CLR at cycle 1; MAC cycles 2..K²+1; done at cycle K²+PIPE_LAT+2. With defaults, done at cycle 13.
- busy is high for cycles 1..13.
- pe_mode_sel holds the latched value from CLR through DONE; it is 0 in IDLE.
- abort in CLR/MAC/DRAIN:
  - Next state IDLE; aborted=1 for one cycle (registered with the transition).
  - done not asserted; pe_en and pe_reg_reset drop to 0; selects return to 0.
- abort in DONE: ignored; done still pulses.
- w_sel/in_sel are 0 in IDLE, CLR and DONE. The tap counter never exceeds K²-1; no wrap-around occurs inside a run.
- Asynchronous reset mid-run: immediate return to IDLE with reset values. No done or aborted pulse follows.

Optional Feature:
- Macro: NPU_SEQ_PERF_EN.
- Defined:
  - perf_cycles increments by 1 every cycle busy=1; saturates at 32'hFFFF_FFFF.
  - Cleared only by reset.
  - Counts aborted runs' cycles too.
- Undefined: perf_cycles tied to 32'd0; no counter flops inferred.

Test Plan:
- Reset, then start=1 for 1 cycle with bcast=0, acc_mode=1, defaults:
  - pe_reg_reset high at cycle 1.
  - pe_en high cycles 2..12.
  - w_sel 0..8 and in_sel 9..17 over cycles 2..10.
  - done=1 only at cycle 13; pe_mode_sel=1 for cycles 1..13.
- Same run with bcast=1 → in_sel 0..8 over cycles 2..10; held at 8 in cycles 11..12.
- start pulses at cycles 5 and 13 during a run → ignored; exactly one done (cycle 13); busy=0 at cycle 14.
- abort=1 at cycle 6 (MAC, tap 4):
  - cycle 7: IDLE, aborted=1, pe_en=0, w_sel=0.
  - No done within 20 cycles.
- start and abort together in IDLE → busy stays 0; no aborted pulse.
- Two back-to-back runs with NPU_SEQ_PERF_EN defined → perf_cycles=26. Without the macro, perf_cycles=0 throughout. Reset asserted at cycle 8 → all outputs 0 immediately.
